// File: rtl/ovf_trap_ctrl_pkg.sv
// Shared definitions for the overflow trap controller: FSM encoding, exception code, default vector.
package ovf_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAP    = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  localparam logic [4:0]  EXC_OV        = 5'd12;
  localparam logic [31:0] TRAP_VEC_DFLT = 32'h8000_0180;

endpackage

// File: rtl/ovf_trap_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/ovf_trap_ctrl.sv
// Signed-overflow trap controller: kills the faulting writeback, redirects to the handler,
// saves epc/cause, and returns to epc on eret.
module ovf_trap_ctrl
  import ovf_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DFLT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_chk_ovf,
  input  logic             ex_ovf,
  input  logic [31:0]      ex_pc,
  input  logic             ie,
  input  logic             eret,
  output logic             wb_kill,
  output logic             flush,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic [4:0]       cause,
  output logic             exl,
  output logic [CNT_W-1:0] ovf_count
);

  state_t state, state_nxt;
  logic   detect;
  logic   trap_taken;
  logic   count_inc;

  assign detect     = ex_valid & ex_chk_ovf & ex_ovf;
  // Gated by rst_n so nothing escapes while reset is asserted.
  assign trap_taken = rst_n & detect & ie & (state == ST_IDLE);
  assign count_inc  = detect & ((state == ST_IDLE) | (state == ST_HANDLER));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (trap_taken) state_nxt = ST_TRAP;
      ST_TRAP:    state_nxt = ST_HANDLER;
      ST_HANDLER: if (eret) state_nxt = ST_RETURN;
      ST_RETURN:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_kill     = trap_taken;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 32'h0;
    if (rst_n) begin
      case (state)
        ST_TRAP: begin
          flush       = 1'b1;
          pc_redirect = 1'b1;
          redirect_pc = TRAP_VEC;
        end
        ST_RETURN: begin
          flush       = 1'b1;
          pc_redirect = 1'b1;
          redirect_pc = epc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epc   <= 32'h0;
      cause <= 5'd0;
      exl   <= 1'b0;
    end else begin
      if (trap_taken) begin
        epc   <= ex_pc;
        cause <= EXC_OV;
      end
      // exl rises one cycle after the redirect and falls one cycle after the return redirect.
      if (state == ST_TRAP) begin
        exl <= 1'b1;
      end else if (state == ST_RETURN) begin
        exl <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (count_inc),
    .q     (ovf_count)
  );

endmodule

// File: tb/tb_ovf_trap_ctrl.sv
// Directed bench for ovf_trap_ctrl; a second instance with CNT_W=2 exercises saturation.
module tb_ovf_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_chk_ovf, ex_ovf, ie, eret;
  logic [31:0] ex_pc;

  logic        wb_kill, flush, pc_redirect, exl;
  logic [31:0] redirect_pc, epc;
  logic [4:0]  cause;
  logic [15:0] ovf_count;

  logic        wb_kill2, flush2, pc_redirect2, exl2;
  logic [31:0] redirect_pc2, epc2;
  logic [4:0]  cause2;
  logic [1:0]  ovf_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ovf_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_chk_ovf(ex_chk_ovf),
    .ex_ovf(ex_ovf), .ex_pc(ex_pc), .ie(ie), .eret(eret),
    .wb_kill(wb_kill), .flush(flush), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .epc(epc), .cause(cause), .exl(exl),
    .ovf_count(ovf_count)
  );

  ovf_trap_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_chk_ovf(ex_chk_ovf),
    .ex_ovf(ex_ovf), .ex_pc(ex_pc), .ie(ie), .eret(eret),
    .wb_kill(wb_kill2), .flush(flush2), .pc_redirect(pc_redirect2),
    .redirect_pc(redirect_pc2), .epc(epc2), .cause(cause2), .exl(exl2),
    .ovf_count(ovf_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_det(input logic d, input logic [31:0] pc);
    ex_valid   = d;
    ex_chk_ovf = d;
    ex_ovf     = d;
    ex_pc      = pc;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_pcr"},   {31'd0, pc_redirect}, 32'd0);
    chk({tag, "_rpc"},   redirect_pc, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ie = 1'b0; eret = 1'b0;
    set_det(1'b0, 32'h0);
    step(); step();
    #1;
    chk("rst_epc", epc, 32'd0);
    chk("rst_cause", {27'd0, cause}, 32'd0);
    chk("rst_exl", {31'd0, exl}, 32'd0);
    chk("rst_cnt", {16'd0, ovf_count}, 32'd0);
    chk("rst_kill", {31'd0, wb_kill}, 32'd0);
    chk_quiet("rst");

    rst_n = 1'b1;
    step();

    // eret in IDLE is ignored
    eret = 1'b1;
    step();
    eret = 1'b0;
    #1;
    chk_quiet("eret_idle");

    // Trap taken in IDLE
    ie = 1'b1;
    set_det(1'b1, 32'h0000_0040);
    #1;
    chk("trap_kill", {31'd0, wb_kill}, 32'd1);
    step();
    // TRAP: detect still asserted but must be ignored
    #1;
    chk("trap_flush", {31'd0, flush}, 32'd1);
    chk("trap_pcr", {31'd0, pc_redirect}, 32'd1);
    chk("trap_rpc", redirect_pc, 32'h8000_0180);
    chk("trap_epc", epc, 32'h40);
    chk("trap_cause", {27'd0, cause}, 32'd12);
    chk("trap_exl", {31'd0, exl}, 32'd0);
    chk("trap_nokill", {31'd0, wb_kill}, 32'd0);
    chk("trap_cnt", {16'd0, ovf_count}, 32'd1);
    set_det(1'b1, 32'h0000_0080);
    step();
    // HANDLER: overflow counted, not trapped
    #1;
    chk("hdl_exl", {31'd0, exl}, 32'd1);
    chk("hdl_cnt_trapcyc", {16'd0, ovf_count}, 32'd1);
    chk_quiet("hdl");
    chk("hdl_nokill", {31'd0, wb_kill}, 32'd0);
    step();
    set_det(1'b0, 32'h0);
    #1;
    chk("hdl_epc_held", epc, 32'h40);
    chk("hdl_cause_held", {27'd0, cause}, 32'd12);
    chk("hdl_cnt", {16'd0, ovf_count}, 32'd2);
    step();
    // eret and detect together in HANDLER: eret wins
    eret = 1'b1;
    set_det(1'b1, 32'h0000_00c0);
    #1;
    chk("both_nokill", {31'd0, wb_kill}, 32'd0);
    step();
    // RETURN: eret and detect still present, both ignored
    #1;
    chk("ret_flush", {31'd0, flush}, 32'd1);
    chk("ret_pcr", {31'd0, pc_redirect}, 32'd1);
    chk("ret_rpc", redirect_pc, 32'h40);
    chk("ret_exl", {31'd0, exl}, 32'd1);
    chk("ret_nokill", {31'd0, wb_kill}, 32'd0);
    chk("ret_cnt", {16'd0, ovf_count}, 32'd3);
    step();
    eret = 1'b0;
    set_det(1'b0, 32'h0);
    #1;
    chk("idle_exl", {31'd0, exl}, 32'd0);
    chk("idle_cnt", {16'd0, ovf_count}, 32'd3);
    chk_quiet("idle");
    step();
    #1;
    chk_quiet("idle2");

    // Masked overflows with ie=0, counting and saturation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ie = 1'b0;
    set_det(1'b1, 32'h0000_0100);
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("mask_kill%0d", i), {31'd0, wb_kill}, 32'd0);
      step();
      #1;
      chk_quiet($sformatf("mask%0d", i));
      chk($sformatf("mask_cnt%0d", i), {16'd0, ovf_count}, i);
      chk($sformatf("sat_cnt%0d", i), {30'd0, ovf_count2}, (i > 3) ? 32'd3 : i);
    end
    chk("mask_epc", epc, 32'd0);
    chk("mask_exl", {31'd0, exl}, 32'd0);

    // Reset asserted during TRAP
    ie = 1'b1;
    set_det(1'b1, 32'h0000_0200);
    step();
    set_det(1'b0, 32'h0);
    #1;
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_trap");
    step();
    #1;
    chk("rst_trap_epc", epc, 32'd0);
    chk("rst_trap_cause", {27'd0, cause}, 32'd0);
    chk("rst_trap_exl", {31'd0, exl}, 32'd0);
    chk("rst_trap_cnt", {16'd0, ovf_count}, 32'd0);
    rst_n = 1'b1;
    step();
    #1;
    chk_quiet("post_rst1");
    chk("post_rst_exl", {31'd0, exl}, 32'd0);
    step();
    #1;
    chk_quiet("post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
